// File: rtl/patch_reduce_scheduler.sv
// Round-robin scheduler for a bank of patch reducers, in-order retire.
// Optional watchdog on the retiring lane: define PATCH_SCHED_TIMEOUT_EN.
module patch_reduce_scheduler #(
  parameter int N_LANE         = 4,
  parameter int PATCH_SIZE     = 6,
  parameter int ROW_SUM_SIZE   = 16,
  parameter int PATCH_SUM_SIZE = 24,
  parameter int TAG_SIZE       = 8,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                             dram_clk,
  input  logic                             reset_n,
  input  logic [ROW_SUM_SIZE-1:0]          in_sum,
  input  logic                             in_valid,
  output logic                             in_ready,
  output logic [N_LANE-1:0]                red_init,
  output logic [ROW_SUM_SIZE-1:0]          red_partial_sum,
  output logic [N_LANE-1:0]                red_valid,
  input  logic [N_LANE-1:0]                red_sum_rdy,
  input  logic [N_LANE*PATCH_SUM_SIZE-1:0] red_sum,
  output logic [N_LANE-1:0]                red_ack,
  output logic [PATCH_SUM_SIZE-1:0]        out_sum,
  output logic [TAG_SIZE-1:0]              out_tag,
  output logic                             out_valid,
  input  logic                             out_ready,
  output logic                             busy,
  output logic                             err
);

  localparam int LW = (N_LANE > 1) ? $clog2(N_LANE) : 1;
  localparam int RW = (PATCH_SIZE > 1) ? $clog2(PATCH_SIZE) : 1;
  localparam logic [LW-1:0] LAST_LANE = LW'(N_LANE - 1);
  localparam logic [RW-1:0] LAST_ROW  = RW'(PATCH_SIZE - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ARM,
    S_FILL,
    S_FULL,
    S_REL
  } lane_st_t;

  lane_st_t                  r_st [N_LANE];
  logic [LW-1:0]             r_alloc_ptr;
  logic [LW-1:0]             r_ret_ptr;
  logic [RW-1:0]             r_row_cnt;
  logic [TAG_SIZE-1:0]       r_out_seq;
  logic [N_LANE-1:0]         r_init;
  logic [N_LANE-1:0]         r_ack;
  logic [PATCH_SUM_SIZE-1:0] r_out_sum;
  logic [TAG_SIZE-1:0]       r_out_tag;
  logic                      r_out_valid;

  logic                      w_arm_fill;
  logic                      w_not_idle;
  logic                      w_fill;
  logic                      w_accept;
  logic                      w_last;
  logic                      w_alloc;
  logic                      w_ret_full;
  logic                      w_retire;
  logic                      w_to_fire;
  logic [PATCH_SUM_SIZE-1:0] w_ret_sum;
  logic [LW-1:0]             w_alloc_nxt;
  logic [LW-1:0]             w_ret_nxt;

  always_comb begin
    w_arm_fill = 1'b0;
    w_not_idle = 1'b0;
    for (int i = 0; i < N_LANE; i++) begin
      if (r_st[i] == S_ARM || r_st[i] == S_FILL)
        w_arm_fill = 1'b1;
      if (r_st[i] != S_IDLE)
        w_not_idle = 1'b1;
    end
  end

  // Only one lane is ever in ARM/FILL, and it is always alloc_ptr.
  assign w_fill   = (r_st[r_alloc_ptr] == S_FILL);
  assign w_accept = in_valid && w_fill;
  assign w_last   = w_accept && (r_row_cnt == LAST_ROW);
  assign w_alloc  = (r_st[r_alloc_ptr] == S_IDLE)
                 && !w_arm_fill && in_valid;

  assign w_ret_full = (r_st[r_ret_ptr] == S_FULL);
  assign w_retire   = w_ret_full && red_sum_rdy[r_ret_ptr]
                   && (!r_out_valid || out_ready);
  assign w_ret_sum  =
    red_sum[int'(r_ret_ptr)*PATCH_SUM_SIZE +: PATCH_SUM_SIZE];

  assign w_alloc_nxt = (r_alloc_ptr == LAST_LANE) ? '0
                     : r_alloc_ptr + 1'b1;
  assign w_ret_nxt   = (r_ret_ptr == LAST_LANE) ? '0
                     : r_ret_ptr + 1'b1;

  always_comb begin
    red_valid = '0;
    if (w_accept)
      red_valid[r_alloc_ptr] = 1'b1;
  end

`ifdef PATCH_SCHED_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT_CYCLES - 1);

  logic [TW-1:0] r_to_cnt;
  logic          r_err;
  logic          w_stall;

  assign w_stall   = w_ret_full && !red_sum_rdy[r_ret_ptr];
  assign w_to_fire = w_stall && (r_to_cnt == TO_LAST);

  always_ff @(posedge dram_clk or negedge reset_n) begin
    if (!reset_n) begin
      r_to_cnt <= '0;
      r_err    <= 1'b0;
    end else begin
      if (!w_stall || w_to_fire)
        r_to_cnt <= '0;
      else
        r_to_cnt <= r_to_cnt + 1'b1;
      if (w_to_fire)
        r_err <= 1'b1;
    end
  end

  assign err = r_err;
`else
  assign w_to_fire = 1'b0;
  assign err       = 1'b0;
`endif

  always_ff @(posedge dram_clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < N_LANE; i++)
        r_st[i] <= S_IDLE;
      r_alloc_ptr <= '0;
      r_ret_ptr   <= '0;
      r_row_cnt   <= '0;
      r_out_seq   <= '0;
      r_init      <= '0;
      r_ack       <= '0;
      r_out_sum   <= '0;
      r_out_tag   <= '0;
      r_out_valid <= 1'b0;
    end else begin
      r_init <= '0;
      r_ack  <= '0;
      for (int i = 0; i < N_LANE; i++) begin
        case (r_st[i])
          S_ARM:   r_st[i] <= S_FILL;
          S_REL:   r_st[i] <= S_IDLE;
          default: r_st[i] <= r_st[i];
        endcase
      end
      if (w_alloc) begin
        r_st[r_alloc_ptr]   <= S_ARM;
        r_init[r_alloc_ptr] <= 1'b1;
        r_row_cnt           <= '0;
      end
      if (w_accept)
        r_row_cnt <= w_last ? '0 : r_row_cnt + 1'b1;
      if (w_last) begin
        r_st[r_alloc_ptr] <= S_FULL;
        r_alloc_ptr       <= w_alloc_nxt;
      end
      // A watchdog release consumes the tag but never reaches the output.
      if (w_retire || w_to_fire) begin
        r_st[r_ret_ptr]  <= S_REL;
        r_ack[r_ret_ptr] <= 1'b1;
        r_out_seq        <= r_out_seq + 1'b1;
        r_ret_ptr        <= w_ret_nxt;
      end
      if (w_retire) begin
        r_out_sum   <= w_ret_sum;
        r_out_tag   <= r_out_seq;
        r_out_valid <= 1'b1;
      end else if (out_ready) begin
        r_out_valid <= 1'b0;
      end
    end
  end

  assign in_ready        = w_fill;
  assign red_partial_sum = in_sum;
  assign red_init        = r_init;
  assign red_ack         = r_ack;
  assign out_sum         = r_out_sum;
  assign out_tag         = r_out_tag;
  assign out_valid       = r_out_valid;
  assign busy            = w_not_idle || r_out_valid;

endmodule

// File: tb/tb_patch_reduce_scheduler.sv
// Bench for patch_reduce_scheduler: reducer models plus an in-order
// scoreboard of expected patch sums and tags.
module tb_patch_reduce_scheduler;

  localparam int NL  = 4;
  localparam int PS  = 6;
  localparam int RS  = 16;
  localparam int SS  = 24;
  localparam int TG  = 8;
  localparam int TO  = 16;
  localparam int BND = 3000;

  logic              clk;
  logic              rst_n;
  logic [RS-1:0]     in_sum;
  logic              in_valid;
  logic              in_ready;
  logic [NL-1:0]     red_init;
  logic [RS-1:0]     red_partial_sum;
  logic [NL-1:0]     red_valid;
  logic [NL-1:0]     red_sum_rdy;
  logic [NL*SS-1:0]  red_sum;
  logic [NL-1:0]     red_ack;
  logic [SS-1:0]     out_sum;
  logic [TG-1:0]     out_tag;
  logic              out_valid;
  logic              out_ready;
  logic              busy;
  logic              err;

  patch_reduce_scheduler #(
    .N_LANE(NL), .PATCH_SIZE(PS), .ROW_SUM_SIZE(RS),
    .PATCH_SUM_SIZE(SS), .TAG_SIZE(TG), .TIMEOUT_CYCLES(TO)
  ) dut (
    .dram_clk(clk), .reset_n(rst_n),
    .in_sum(in_sum), .in_valid(in_valid), .in_ready(in_ready),
    .red_init(red_init), .red_partial_sum(red_partial_sum),
    .red_valid(red_valid), .red_sum_rdy(red_sum_rdy),
    .red_sum(red_sum), .red_ack(red_ack),
    .out_sum(out_sum), .out_tag(out_tag), .out_valid(out_valid),
    .out_ready(out_ready), .busy(busy), .err(err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  task automatic chk(input string t, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", t, got, exp);
    end
  endtask

  // Reducer models: clear on init, add on valid, ready after a delay.
  logic [SS-1:0] m_acc [NL];
  int            m_cnt [NL];
  int            m_hold[NL];
  int            m_dly [NL];
  bit            m_never[NL];
  logic [NL-1:0] m_rdy;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NL; i++) begin
        m_acc[i]  <= '0;
        m_cnt[i]  <= 0;
        m_hold[i] <= 0;
      end
      m_rdy <= '0;
    end else begin
      for (int i = 0; i < NL; i++) begin
        if (red_init[i]) begin
          m_acc[i]  <= '0;
          m_cnt[i]  <= 0;
          m_hold[i] <= 0;
          m_rdy[i]  <= 1'b0;
        end else if (red_valid[i]) begin
          m_acc[i] <= m_acc[i] + SS'(red_partial_sum);
          m_cnt[i] <= m_cnt[i] + 1;
        end else if (red_ack[i]) begin
          m_rdy[i] <= 1'b0;
          m_cnt[i] <= 0;
        end else if (m_cnt[i] == PS && !m_rdy[i] && !m_never[i]) begin
          if (m_hold[i] >= m_dly[i]) m_rdy[i] <= 1'b1;
          else m_hold[i] <= m_hold[i] + 1;
        end
      end
    end
  end

  always_comb begin
    red_sum_rdy = m_rdy;
    for (int i = 0; i < NL; i++)
      red_sum[i*SS +: SS] = m_acc[i];
  end

  logic [SS-1:0] q_sum[$];
  logic [TG-1:0] q_tag[$];
  int            q_ack[$];
  int            init_cnt[NL];
  int            val_cnt[NL];
  int            ack_cnt[NL];
  int            exp_tag;

  always @(negedge clk) begin
    if (rst_n) begin
      for (int i = 0; i < NL; i++) begin
        if (red_init[i])  init_cnt[i]++;
        if (red_valid[i]) val_cnt[i]++;
        if (red_ack[i]) begin
          ack_cnt[i]++;
          q_ack.push_back(i);
        end
      end
      if (out_valid && out_ready) begin
        if (q_sum.size() == 0) begin
          chk("sb_unexpected", {24'd0, out_tag}, 32'hFFFF_FFFF);
        end else begin
          chk("sb_sum", 32'(out_sum), 32'(q_sum.pop_front()));
          chk("sb_tag", 32'(out_tag), 32'(q_tag.pop_front()));
        end
      end
    end
  end

  task automatic clear_stats();
    for (int i = 0; i < NL; i++) begin
      init_cnt[i] = 0;
      val_cnt[i]  = 0;
      ack_cnt[i]  = 0;
      m_dly[i]    = 2;
      m_never[i]  = 0;
    end
    q_sum.delete();
    q_tag.delete();
    q_ack.delete();
    exp_tag = 0;
  endtask

  task automatic do_reset();
    rst_n    = 1'b0;
    in_valid = 1'b0;
    in_sum   = '0;
    repeat (2) @(negedge clk);
    clear_stats();
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  // Called at a negedge; returns at the negedge after acceptance.
  task automatic send_row(input logic [RS-1:0] v, output int waited);
    int n = 0;
    in_sum   = v;
    in_valid = 1'b1;
    while (!in_ready && n < BND) begin
      @(negedge clk);
      n++;
    end
    if (n >= BND) chk("row_timeout", 32'(n), 32'(0));
    waited = n;
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic send_patch(input bit rnd, input int gap,
                            input bit expect_out);
    logic [RS-1:0] rows[PS];
    logic [SS-1:0] s = '0;
    int w;
    for (int r = 0; r < PS; r++) begin
      rows[r] = rnd ? RS'($urandom_range(0, 60000)) : RS'(r + 1);
      s = s + SS'(rows[r]);
    end
    if (expect_out) begin
      q_sum.push_back(s);
      q_tag.push_back(TG'(exp_tag));
    end
    exp_tag++;
    for (int r = 0; r < PS; r++) begin
      send_row(rows[r], w);
      repeat (gap) @(negedge clk);
    end
  endtask

  task automatic wait_drain();
    int n = 0;
    while ((q_sum.size() != 0 || busy) && n < BND) begin
      @(negedge clk);
      n++;
    end
    chk("drain", 32'(n < BND), 32'd1);
  endtask

  int w0;
  int tot;

  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_sum    = '0;
    out_ready = 1'b1;
    clear_stats();
    #1;
    chk("rst_in_ready", 32'(in_ready), 0);
    chk("rst_out_valid", 32'(out_valid), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_init", 32'(red_init), 0);
    chk("rst_ack", 32'(red_ack), 0);
    chk("rst_out_tag", 32'(out_tag), 0);
    chk("rst_err", 32'(err), 0);
    do_reset();

    // Single patch of rows 1..6 on lane 0, sum 21, tag 0.
    q_sum.push_back(24'd21);
    q_tag.push_back(8'd0);
    exp_tag = 1;
    send_row(16'd1, w0);
    chk("first_row_latency", 32'(w0), 32'd2);
    for (int r = 2; r <= PS; r++) send_row(RS'(r), w0);
    wait_drain();
    chk("t1_init0", 32'(init_cnt[0]), 1);
    chk("t1_valid0", 32'(val_cnt[0]), 6);
    chk("t1_ack0", 32'(ack_cnt[0]), 1);
    send_patch(1, 0, 1);
    wait_drain();
    chk("t1_init1", 32'(init_cnt[1]), 1);

    // Output stalled: four lanes plus the output register absorb five
    // patches, the sixth must be held off.
    do_reset();
    out_ready = 1'b0;
    fork
      begin
        for (int p = 0; p < 6; p++) send_patch(1, 0, 1);
      end
      begin
        repeat (80) @(negedge clk);
        tot = 0;
        for (int i = 0; i < NL; i++) tot += val_cnt[i];
        chk("bp_rows", 32'(tot), 32'(5 * PS));
        chk("bp_in_ready", 32'(in_ready), 0);
        chk("bp_out_valid", 32'(out_valid), 1);
        chk("bp_out_tag", 32'(out_tag), 0);
        out_ready = 1'b1;
      end
    join
    wait_drain();
    chk("bp_init0", 32'(init_cnt[0]), 2);

    // Lane 2 ready long before lane 1: retire order must hold.
    do_reset();
    m_dly[1] = 40;
    m_dly[2] = 0;
    for (int p = 0; p < 3; p++) send_patch(1, 0, 1);
    wait_drain();
    chk("ord_n", 32'(q_ack.size()), 3);
    for (int i = 0; i < 3; i++)
      if (q_ack.size() > 0) chk("ord_ack", 32'(q_ack.pop_front()), 32'(i));

    // Reset in the middle of a patch.
    do_reset();
    for (int r = 0; r < 3; r++) send_row(RS'(r + 7), w0);
    in_valid = 1'b1;
    rst_n    = 1'b0;
    #1;
    chk("mid_rst_in_ready", 32'(in_ready), 0);
    chk("mid_rst_valid", 32'(red_valid), 0);
    chk("mid_rst_busy", 32'(busy), 0);
    chk("mid_rst_out_valid", 32'(out_valid), 0);
    do_reset();
    send_patch(0, 0, 1);
    wait_drain();
    chk("mid_rst_lane0", 32'(init_cnt[0]), 1);

    // Sparse input: one row every third cycle.
    do_reset();
    send_patch(1, 2, 1);
    send_patch(1, 2, 1);
    wait_drain();
    chk("gap_valid0", 32'(val_cnt[0]), 6);
    chk("gap_valid1", 32'(val_cnt[1]), 6);
    chk("gap_inits", 32'(init_cnt[0] + init_cnt[1] + init_cnt[2]), 2);

`ifdef PATCH_SCHED_TIMEOUT_EN
    do_reset();
    m_never[0] = 1;
    send_patch(1, 0, 0);
    w0 = 0;
    while (!err && w0 < 200) begin
      @(negedge clk);
      w0++;
    end
    chk("to_cycles", 32'(w0), 32'(TO));
    chk("to_ack0", 32'(ack_cnt[0]), 1);
    m_never[0] = 0;
    send_patch(1, 0, 1);
    wait_drain();
    chk("to_sticky", 32'(err), 1);
`else
    chk("err_idle", 32'(err), 0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
